// File: rtl/neuron_mac_gen.sv
// Runtime-configured fully-connected neuron: weights/bias loaded over the shared
// config bus, streamed inputs MAC'd with saturation, ReLU or linear activation.
module neuron_mac_gen #(
    parameter int LAYER_NO   = 1,
    parameter int NEURON_NO  = 0,
    parameter int NUM_WEIGHT = 30,
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           cfg_layer,
    input  logic [31:0]           cfg_neuron,
    input  logic                  weight_valid,
    input  logic [31:0]           weight_value,
    input  logic                  bias_valid,
    input  logic [31:0]           bias_value,
    output logic                  cfg_drop,
    input  logic                  act_sel,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  out_ready
);
    // Handshake: a beat/result transfers on the rising edge where valid & ready
    // are both high; out_valid/out_data hold steady until that edge.

    localparam int AW2 = 2 * DATA_WIDTH;
    localparam int CW  = $clog2(NUM_WEIGHT + 1);
    localparam int IW  = (NUM_WEIGHT > 1) ? $clog2(NUM_WEIGHT) : 1;

    localparam logic [31:0] LAYER_ID  = LAYER_NO;
    localparam logic [31:0] NEURON_ID = NEURON_NO;

    localparam logic signed [AW2-1:0] ACC_MAX = {1'b0, {(AW2-1){1'b1}}};
    localparam logic signed [AW2-1:0] ACC_MIN = {1'b1, {(AW2-1){1'b0}}};
    localparam logic signed [AW2-1:0] OUT_MAX = {{(AW2-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [AW2-1:0] OUT_MIN = {{(AW2-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        ST_ACCUM = 3'd0,
        ST_DRAIN = 3'd1,
        ST_BIAS  = 3'd2,
        ST_ACT   = 3'd3,
        ST_OUT   = 3'd4
    } state_t;

    state_t state, state_next;

    logic signed [DATA_WIDTH-1:0] ram [NUM_WEIGHT];
    logic [IW-1:0]                wptr;
    logic [CW-1:0]                count;
    logic signed [DATA_WIDTH-1:0] bias_reg;
    logic signed [AW2-1:0]        prod;
    logic                         prod_vld;
    logic signed [AW2-1:0]        acc;
    logic                         act_q;

    logic                  cfg_match;
    logic                  busy;
    logic                  weight_wr;
    logic                  bias_wr;
    logic                  beat_fire;
    logic [IW-1:0]         rd_idx;
    logic signed [AW2-1:0] prod_next;
    logic signed [AW2-1:0] bias_ext;

    function automatic logic signed [AW2-1:0] sat_add(input logic signed [AW2-1:0] a,
                                                       input logic signed [AW2-1:0] b);
        logic signed [AW2-1:0] s;
        s = a + b;
        if ((a[AW2-1] == b[AW2-1]) && (s[AW2-1] != a[AW2-1]))
            s = a[AW2-1] ? ACC_MIN : ACC_MAX;
        return s;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] activate(input logic signed [AW2-1:0] a,
                                                        input logic linear);
        logic signed [AW2-1:0] scaled;
        logic signed [AW2-1:0] clamped;
        scaled = a >>> FRAC_BITS;
        if (scaled > OUT_MAX)
            clamped = OUT_MAX;
        else if (scaled < 0 && !linear)
            clamped = '0;
        else if (scaled < OUT_MIN)
            clamped = OUT_MIN;
        else
            clamped = scaled;
        return clamped[DATA_WIDTH-1:0];
    endfunction

    assign cfg_match = (cfg_layer == LAYER_ID) && (cfg_neuron == NEURON_ID);
    assign busy      = (state != ST_ACCUM) || (count != '0);
    assign weight_wr = cfg_match && weight_valid && !busy && !rst;
    assign bias_wr   = cfg_match && bias_valid && !busy;
    assign in_ready  = (state == ST_ACCUM) && (count < CW'(NUM_WEIGHT));
    assign beat_fire = in_valid && in_ready;
    assign rd_idx    = count[IW-1:0];
    assign prod_next = $signed(in_data) * ram[rd_idx];
    // Bias is brought up to the product scale (2*FRAC_BITS fractional bits).
    assign bias_ext  = $signed({{DATA_WIDTH{bias_reg[DATA_WIDTH-1]}}, bias_reg}) <<< FRAC_BITS;

    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_ACCUM;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_ACCUM: if (beat_fire && count == CW'(NUM_WEIGHT - 1)) state_next = ST_DRAIN;
            ST_DRAIN: state_next = ST_BIAS;
            ST_BIAS:  state_next = ST_ACT;
            ST_ACT:   state_next = ST_OUT;
            ST_OUT:   if (out_ready) state_next = ST_ACCUM;
            default:  state_next = ST_ACCUM;
        endcase
    end

    // Weight RAM is deliberately not reset so weights survive rst.
    always_ff @(posedge clk) begin
        if (weight_wr)
            ram[wptr] <= weight_value[DATA_WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr      <= '0;
            count     <= '0;
            bias_reg  <= '0;
            prod      <= '0;
            prod_vld  <= 1'b0;
            acc       <= '0;
            act_q     <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            cfg_drop  <= 1'b0;
        end else begin
            cfg_drop <= cfg_match && (weight_valid || bias_valid) && busy;
            if (weight_wr)
                wptr <= (wptr == IW'(NUM_WEIGHT - 1)) ? '0 : wptr + IW'(1);
            if (bias_wr)
                bias_reg <= bias_value[DATA_WIDTH-1:0];

            prod_vld <= beat_fire;
            if (beat_fire) begin
                prod  <= prod_next;
                count <= count + CW'(1);
            end

            case (state)
                ST_ACCUM, ST_DRAIN: begin
                    if (prod_vld)
                        acc <= sat_add(acc, prod);
                end
                ST_BIAS: begin
                    acc   <= sat_add(acc, bias_ext);
                    act_q <= act_sel;
                end
                ST_ACT: begin
                    out_data  <= activate(acc, act_q);
                    out_valid <= 1'b1;
                end
                ST_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        acc       <= '0;
                        count     <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    generate
        if (DATA_WIDTH < 32) begin : g_unused
            logic unused_cfg_bits;
            assign unused_cfg_bits = ^{weight_value[31:DATA_WIDTH], bias_value[31:DATA_WIDTH]};
        end
    endgenerate

endmodule

// File: tb/tb_neuron_mac_gen.sv
// Directed bench for neuron_mac_gen (4 weights, Q8.8): config bus, latency,
// saturation, backpressure, dropped writes and mid-inference reset.
module tb_neuron_mac_gen;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   cfg_layer;
    logic [31:0]   cfg_neuron;
    logic          weight_valid;
    logic [31:0]   weight_value;
    logic          bias_valid;
    logic [31:0]   bias_value;
    logic          cfg_drop;
    logic          act_sel;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready;

    int n_checks = 0;
    int n_errors = 0;

    neuron_mac_gen #(
        .LAYER_NO   (1),
        .NEURON_NO  (0),
        .NUM_WEIGHT (4),
        .DATA_WIDTH (DW),
        .FRAC_BITS  (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_layer    (cfg_layer),
        .cfg_neuron   (cfg_neuron),
        .weight_valid (weight_valid),
        .weight_value (weight_value),
        .bias_valid   (bias_valid),
        .bias_value   (bias_value),
        .cfg_drop     (cfg_drop),
        .act_sel      (act_sel),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_ready    (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // All drivers start and end on a falling edge.
    task automatic cfg_write(input logic [31:0] layer, input logic [31:0] neuron,
                             input logic wv, input logic [15:0] wval,
                             input logic bv, input logic [15:0] bval,
                             output logic drop);
        cfg_layer    = layer;
        cfg_neuron   = neuron;
        weight_valid = wv;
        weight_value = {16'hDEAD, wval};
        bias_valid   = bv;
        bias_value   = {16'hBEEF, bval};
        @(negedge clk);
        weight_valid = 1'b0;
        bias_valid   = 1'b0;
        drop         = cfg_drop;
    endtask

    task automatic load_weight(input logic [15:0] val);
        logic drop;
        cfg_write(32'd1, 32'd0, 1'b1, val, 1'b0, 16'h0, drop);
        check_eq("load_w_no_drop", {31'd0, drop}, 32'd0);
    endtask

    task automatic load_bias(input logic [15:0] val);
        logic drop;
        cfg_write(32'd1, 32'd0, 1'b0, 16'h0, 1'b1, val, drop);
        check_eq("load_b_no_drop", {31'd0, drop}, 32'd0);
    endtask

    task automatic send_beat(input logic [DW-1:0] d);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready)
            check_eq("beat_timeout", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic finish_inference(input string tag, input logic [DW-1:0] exp, input int hold);
        int lat;
        lat = 1;
        check_eq({tag, "_rdy_low"}, {31'd0, in_ready}, 32'd0);
        while (!out_valid && lat < 12) begin
            @(negedge clk);
            lat++;
        end
        check_eq({tag, "_latency"}, lat, 32'd4);
        check_eq({tag, "_data"}, {16'd0, out_data}, {16'd0, exp});
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            in_data  = 16'h7FFF;
            check_eq({tag, "_hold_vld"}, {31'd0, out_valid}, 32'd1);
            check_eq({tag, "_hold_data"}, {16'd0, out_data}, {16'd0, exp});
            check_eq({tag, "_hold_rdy"}, {31'd0, in_ready}, 32'd0);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_eq({tag, "_vld_clr"}, {31'd0, out_valid}, 32'd0);
        check_eq({tag, "_rdy_back"}, {31'd0, in_ready}, 32'd1);
    endtask

    task automatic run4(input string tag, input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                        input logic [DW-1:0] d2, input logic [DW-1:0] d3,
                        input logic [DW-1:0] exp, input int hold);
        send_beat(d0);
        send_beat(d1);
        send_beat(d2);
        send_beat(d3);
        finish_inference(tag, exp, hold);
    endtask

    initial begin : main
        logic drop;
        logic seen;

        rst = 1'b1;
        cfg_layer = '0; cfg_neuron = '0;
        weight_valid = 1'b0; weight_value = '0;
        bias_valid = 1'b0; bias_value = '0;
        act_sel = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_out_data", {16'd0, out_data}, 32'd0);
        check_eq("rst_cfg_drop", {31'd0, cfg_drop}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Weights 1.0, bias 0.5, inputs 2.0 -> 8.5 under ReLU, held 5 cycles.
        for (int i = 0; i < 4; i++) load_weight(16'h0100);
        load_bias(16'h0080);
        act_sel = 1'b0;
        run4("basic", 16'h0200, 16'h0200, 16'h0200, 16'h0200, 16'h0880, 5);

        // Non-matching writes are ignored without a drop pulse.
        cfg_write(32'd1, 32'd1, 1'b1, 16'h0300, 1'b0, 16'h0, drop);
        check_eq("nomatch_neuron_drop", {31'd0, drop}, 32'd0);
        cfg_write(32'd2, 32'd0, 1'b1, 16'h0300, 1'b0, 16'h0, drop);
        check_eq("nomatch_layer_drop", {31'd0, drop}, 32'd0);
        cfg_write(32'd1, 32'd1, 1'b0, 16'h0, 1'b1, 16'h7000, drop);
        check_eq("nomatch_bias_drop", {31'd0, drop}, 32'd0);
        act_sel = 1'b1;
        run4("nomatch", 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0480, 0);

        // Simultaneous weight (RAM[0]=2.0) and bias (-1.0) writes.
        cfg_write(32'd1, 32'd0, 1'b1, 16'h0200, 1'b1, 16'hFF00, drop);
        check_eq("dual_wr_no_drop", {31'd0, drop}, 32'd0);
        act_sel = 1'b0;
        run4("neg_relu", 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0);
        act_sel = 1'b1;
        run4("neg_linear", 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'hFF00, 0);
        run4("dual_wr", 16'h0100, 16'h0000, 16'h0000, 16'h0000, 16'h0100, 0);

        // Saturation in both directions.
        for (int i = 0; i < 4; i++) load_weight(16'h7FFF);
        load_bias(16'h7FFF);
        run4("sat_pos", 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 0);
        run4("sat_neg", 16'h8001, 16'h8001, 16'h8001, 16'h8001, 16'h8000, 0);

        // Five writes leave the write pointer at index 2, the third beat's weight.
        for (int i = 0; i < 5; i++) load_weight(16'h0100);
        load_bias(16'h0080);
        send_beat(16'h0100);
        send_beat(16'h0100);
        cfg_write(32'd1, 32'd0, 1'b1, 16'h0500, 1'b0, 16'h0, drop);
        check_eq("busy_drop_pulse", {31'd0, drop}, 32'd1);
        @(negedge clk);
        check_eq("busy_drop_clear", {31'd0, cfg_drop}, 32'd0);
        send_beat(16'h0200);
        send_beat(16'h0100);
        finish_inference("busy_drop", 16'h0580, 0);

        // Reset after beat 3 discards the inference and clears bias.
        send_beat(16'h0100);
        send_beat(16'h0100);
        send_beat(16'h0100);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        check_eq("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            if (out_valid) seen = 1'b1;
            @(negedge clk);
        end
        check_eq("mid_rst_no_out", {31'd0, seen}, 32'd0);
        run4("after_rst", 16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0A00, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
